// File: rtl/chimera_bypass_switch_if.sv
// Per-cluster wide-channel handshake bundle for chimera_bypass_switch.
// timeout_o exists only when CHIMERA_BYPASS_TIMEOUT_EN is defined.
interface chimera_bypass_switch_if #(
  parameter int NumClusters = 5
);
  logic [NumClusters-1:0] bypass_req_i, bypass_o, busy_o;
  logic [NumClusters-1:0] aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
  logic [NumClusters-1:0] ar_valid_i, ar_ready_o, ar_valid_o, ar_ready_i;
  logic [NumClusters-1:0] b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
`ifdef CHIMERA_BYPASS_TIMEOUT_EN
  logic [NumClusters-1:0] timeout_o;
`endif

  // Switch side
  modport slave (
    input  bypass_req_i, aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i,
           b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i,
`ifdef CHIMERA_BYPASS_TIMEOUT_EN
    output timeout_o,
`endif
    output bypass_o, busy_o, aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o
  );

  // System side (cluster port, downstream routing and mode control)
  modport master (
    output bypass_req_i, aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i,
           b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i,
`ifdef CHIMERA_BYPASS_TIMEOUT_EN
    input  timeout_o,
`endif
    input  bypass_o, busy_o, aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o
  );
endinterface

// File: rtl/chimera_bypass_switch.sv
// Per-cluster wide-memory bypass sequencer: drains outstanding AW/AR before switching mode.
// Optional drain timeout enabled by defining CHIMERA_BYPASS_TIMEOUT_EN.
module chimera_bypass_switch #(
  parameter int NumClusters    = 5,
  parameter int MaxOutstanding = 8,
  parameter int TimeoutCycles  = 1024,
  parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input logic                    clk_i,
  input logic                    rst_i,
  chimera_bypass_switch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, SETTLE} state_e;

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  if (MaxOutstanding < 1 || TimeoutCycles < 1) begin : g_bad_param
    $error("chimera_bypass_switch: MaxOutstanding and TimeoutCycles must be >= 1");
  end

  state_e                 state_q [NumClusters];
  logic [CntWidth-1:0]    wr_cnt  [NumClusters];
  logic [CntWidth-1:0]    rd_cnt  [NumClusters];
  logic [NumClusters-1:0] target_q, bypass_q, busy_q;
  logic [NumClusters-1:0] pass_w, pass_r, aw_hs, ar_hs, b_hs, r_hs, to_flag;

  function automatic logic [CntWidth-1:0] next_cnt(input logic [CntWidth-1:0] cnt,
                                                   input logic inc, input logic dec);
    if (inc && !dec)                return cnt + CntWidth'(1);
    if (dec && !inc && cnt != '0)   return cnt - CntWidth'(1);
    return cnt;
  endfunction

  always_comb begin
    pass_w = '0;
    pass_r = '0;
    for (int c = 0; c < NumClusters; c++) begin
      pass_w[c] = (state_q[c] == IDLE) && (wr_cnt[c] != CntMax);
      pass_r[c] = (state_q[c] == IDLE) && (rd_cnt[c] != CntMax);
    end
  end

  assign bus.aw_valid_o = bus.aw_valid_i & pass_w;
  assign bus.aw_ready_o = bus.aw_ready_i & pass_w;
  assign bus.ar_valid_o = bus.ar_valid_i & pass_r;
  assign bus.ar_ready_o = bus.ar_ready_i & pass_r;

  assign aw_hs = bus.aw_valid_o & bus.aw_ready_i;
  assign ar_hs = bus.ar_valid_o & bus.ar_ready_i;
  assign b_hs  = bus.b_valid_i & bus.b_ready_i;
  assign r_hs  = bus.r_valid_i & bus.r_ready_i & bus.r_last_i;

  assign bus.bypass_o = bypass_q;
  assign bus.busy_o   = busy_q;

`ifdef CHIMERA_BYPASS_TIMEOUT_EN
  localparam int ToW = $clog2(TimeoutCycles + 1);
  logic [ToW-1:0]         to_cnt [NumClusters];
  logic [NumClusters-1:0] timeout_q;
  assign to_flag       = timeout_q;
  assign bus.timeout_o = timeout_q;
`else
  assign to_flag = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      target_q <= '0;
      bypass_q <= '0;
      busy_q   <= '0;
      for (int c = 0; c < NumClusters; c++) begin
        state_q[c] <= IDLE;
        wr_cnt[c]  <= '0;
        rd_cnt[c]  <= '0;
      end
`ifdef CHIMERA_BYPASS_TIMEOUT_EN
      timeout_q <= '0;
      for (int c = 0; c < NumClusters; c++) to_cnt[c] <= '0;
`endif
    end else begin
      for (int c = 0; c < NumClusters; c++) begin
        wr_cnt[c] <= next_cnt(wr_cnt[c], aw_hs[c], b_hs[c]);
        rd_cnt[c] <= next_cnt(rd_cnt[c], ar_hs[c], r_hs[c]);
`ifdef CHIMERA_BYPASS_TIMEOUT_EN
        to_cnt[c] <= (state_q[c] == DRAIN) ? to_cnt[c] + ToW'(1) : '0;
        if (timeout_q[c] && bus.bypass_req_i[c] == bypass_q[c]) timeout_q[c] <= 1'b0;
`endif
        case (state_q[c])
          IDLE: begin
            if (bus.bypass_req_i[c] != bypass_q[c] && !to_flag[c]) begin
              target_q[c] <= bus.bypass_req_i[c];
              busy_q[c]   <= 1'b1;
              state_q[c]  <= DRAIN;
            end
          end
          DRAIN: begin
            if (wr_cnt[c] == '0 && rd_cnt[c] == '0) begin
              bypass_q[c] <= target_q[c];
              state_q[c]  <= SETTLE;
            end
`ifdef CHIMERA_BYPASS_TIMEOUT_EN
            // Give up without touching the applied mode; sticky flag blocks retries
            else if (to_cnt[c] == ToW'(TimeoutCycles - 1)) begin
              timeout_q[c] <= 1'b1;
              busy_q[c]    <= 1'b0;
              state_q[c]   <= IDLE;
            end
`endif
          end
          default: begin
            busy_q[c]  <= 1'b0;
            state_q[c] <= IDLE;
          end
        endcase
      end
    end
  end

  // A response with nothing outstanding indicates a protocol error upstream
  for (genvar c = 0; c < NumClusters; c++) begin : g_chk
    a_wr_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(b_hs[c] && !aw_hs[c] && wr_cnt[c] == '0));
    a_rd_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(r_hs[c] && !ar_hs[c] && rd_cnt[c] == '0));
  end

endmodule

// File: tb/tb_chimera_bypass_switch.sv
// Directed bench for chimera_bypass_switch: pass-through, drain/settle timing, limits, reset, timeout.
module tb_chimera_bypass_switch;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  chimera_bypass_switch_if #(.NumClusters(N)) bus ();

  chimera_bypass_switch #(
    .NumClusters(N), .MaxOutstanding(8), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    bus.bypass_req_i = '0;
    bus.aw_valid_i = '0; bus.aw_ready_i = '0;
    bus.ar_valid_i = '0; bus.ar_ready_i = '0;
    bus.b_valid_i  = '0; bus.b_ready_i  = '0;
    bus.r_valid_i  = '0; bus.r_ready_i  = '0; bus.r_last_i = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_bypass", bus.bypass_o, 5'b00000);
    check("reset_busy",   bus.busy_o,   5'b00000);

    // Pass-through with disjoint valid/ready so nothing is counted
    bus.aw_valid_i = 5'b10101; bus.aw_ready_i = 5'b01010;
    bus.ar_valid_i = 5'b11000; bus.ar_ready_i = 5'b00111;
    #1;
    check("pass_aw_valid", bus.aw_valid_o, 5'b10101);
    check("pass_aw_ready", bus.aw_ready_o, 5'b01010);
    check("pass_ar_valid", bus.ar_valid_o, 5'b11000);
    check("pass_ar_ready", bus.ar_ready_o, 5'b00111);
    tick();
    check("pass_bypass", bus.bypass_o, 5'b00000);
    check("pass_busy",   bus.busy_o,   5'b00000);
    bus.aw_valid_i = '0; bus.aw_ready_i = '0;
    bus.ar_valid_i = '0; bus.ar_ready_i = '0;

    // Channel 0 switch with no traffic
    bus.bypass_req_i = 5'b00001;
    tick();  // edge t
    bus.aw_valid_i = 5'b11111;
    #1;
    check("ch0_t_busy",     bus.busy_o,     5'b00001);
    check("ch0_t_bypass",   bus.bypass_o,   5'b00000);
    check("ch0_t_gate",     bus.aw_valid_o, 5'b11110);
    tick();  // edge t+1
    check("ch0_t1_bypass",  bus.bypass_o,   5'b00001);
    check("ch0_t1_busy",    bus.busy_o,     5'b00001);
    check("ch0_t1_gate",    bus.aw_valid_o, 5'b11110);
    tick();  // edge t+2
    check("ch0_t2_busy",    bus.busy_o,     5'b00000);
    check("ch0_t2_pass",    bus.aw_valid_o, 5'b11111);
    check("ch0_t2_bypass",  bus.bypass_o,   5'b00001);
    bus.aw_valid_i = '0;

    // Channel 1: three writes outstanding, responses at t+5, t+9, t+12
    bus.aw_valid_i = 5'b00010; bus.aw_ready_i = 5'b00010;
    tick(); tick(); tick();
    bus.aw_valid_i = '0; bus.aw_ready_i = '0;
    bus.bypass_req_i = 5'b00011;
    tick();  // edge t
    bus.aw_valid_i = 5'b00010; bus.aw_ready_i = 5'b00010;
    #1;
    check("ch1_t_gate_ready", bus.aw_ready_o, 5'b00000);
    check("ch1_t_busy",       bus.busy_o,     5'b00010);
    for (int i = 1; i <= 13; i++) begin
      if (i == 5 || i == 9 || i == 12) begin
        bus.b_valid_i = 5'b00010; bus.b_ready_i = 5'b00010;
      end else begin
        bus.b_valid_i = '0; bus.b_ready_i = '0;
      end
      tick();
      check($sformatf("ch1_drain_ready_%0d", i), bus.aw_ready_o, 5'b00000);
      check($sformatf("ch1_drain_bypass_%0d", i), bus.bypass_o,
            (i == 13) ? 5'b00011 : 5'b00001);
    end
    bus.b_valid_i = '0; bus.b_ready_i = '0;
    bus.aw_valid_i = '0; bus.aw_ready_i = '0;
    tick();
    check("ch1_done_busy", bus.busy_o, 5'b00000);

    // Channel 2: fill reads to the limit
    bus.ar_valid_i = 5'b00100; bus.ar_ready_i = 5'b00100;
    for (int i = 0; i < 8; i++) tick();
    check("rd_full_ready", bus.ar_ready_o, 5'b00000);
    check("rd_full_valid", bus.ar_valid_o, 5'b00000);
    bus.r_valid_i = 5'b00100; bus.r_ready_i = 5'b00100; bus.r_last_i = 5'b00100;
    tick();  // R frees one slot (AR gated this cycle): 7
    check("rd_slot_open", bus.ar_ready_o, 5'b00100);
    tick();  // R and AR together: stays 7
    check("rd_same_cycle", bus.ar_ready_o, 5'b00100);
    bus.r_valid_i = '0;
    tick();  // AR only: back to 8
    check("rd_refull", bus.ar_ready_o, 5'b00000);
    bus.ar_valid_i = '0; bus.ar_ready_i = '0;
    // Non-last beats do not decrement
    bus.r_valid_i = 5'b00100; bus.r_last_i = 5'b00000;
    tick();
    check("rd_nonlast", bus.ar_ready_o, 5'b00000);
    bus.r_last_i = 5'b00100;
    for (int i = 0; i < 6; i++) tick();  // down to 2
    bus.r_valid_i = '0; bus.r_ready_i = '0; bus.r_last_i = '0;

    // Reset during drain with two reads outstanding
    bus.bypass_req_i = 5'b00111;
    tick();
    check("rst_pre_busy", bus.busy_o, 5'b00100);
    tick(); tick();
    check("rst_pre_stuck", bus.bypass_o, 5'b00011);
    rst = 1'b1;
    bus.bypass_req_i = '0;
    tick();
    rst = 1'b0;
    bus.ar_valid_i = 5'b00100; bus.ar_ready_i = 5'b00000;
    #1;
    check("rst_bypass",   bus.bypass_o,   5'b00000);
    check("rst_busy",     bus.busy_o,     5'b00000);
    check("rst_ar_pass",  bus.ar_valid_o, 5'b00100);
    bus.ar_valid_i = '0;
    bus.bypass_req_i = 5'b00100;
    tick();
    check("rst_cnt_busy", bus.busy_o,   5'b00100);
    tick();  // counters cleared, so the flip is immediate
    check("rst_cnt_flip", bus.bypass_o, 5'b00100);
    tick();
    check("rst_cnt_idle", bus.busy_o,   5'b00000);

`ifdef CHIMERA_BYPASS_TIMEOUT_EN
    // Channel 3: one write never answered
    check("to_init", bus.timeout_o, 5'b00000);
    bus.aw_valid_i = 5'b01000; bus.aw_ready_i = 5'b01000;
    tick();
    bus.aw_valid_i = '0; bus.aw_ready_i = '0;
    bus.bypass_req_i = 5'b01100;
    tick();  // edge t: DRAIN
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("to_wait_%0d", i), bus.timeout_o, 5'b00000);
    end
    tick();  // edge t+16
    check("to_fire",   bus.timeout_o, 5'b01000);
    check("to_bypass", bus.bypass_o,  5'b00100);
    check("to_busy",   bus.busy_o,    5'b00000);
    tick(); tick();
    check("to_noretry", bus.busy_o,   5'b00000);
    check("to_sticky",  bus.timeout_o, 5'b01000);
    bus.bypass_req_i = 5'b00100;
    tick();
    check("to_clear", bus.timeout_o, 5'b00000);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
